// File: rtl/fetch_stage.sv
// fetch_stage: owns PCF, fetches over a req/ack instruction memory port and
// loads the IF/ID register (InstrD, PCPlus4D, ValidD) for the decode stage.
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   StallF, StallD            hazard-unit holds for PC and IF/ID register
//   PCSrcD, JumpD             decode-stage redirects (JumpD has priority)
//   PCBranchD, PCJumpD        redirect targets (bits [1:0] ignored)
//   imem_req, imem_addr       fetch request, held stable until imem_ack
//   imem_ack, imem_rdata      memory response and instruction word
//   InstrD, PCPlus4D, ValidD  IF/ID pipeline register
//   ImemStall                 fetch is waiting on memory
module fetch_stage #(
    parameter int             W        = 32,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         PCSrcD,
    input  logic         JumpD,
    input  logic [W-1:0] PCBranchD,
    input  logic [W-1:0] PCJumpD,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] InstrD,
    output logic [W-1:0] PCPlus4D,
    output logic         ValidD,
    output logic         ImemStall
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [W-1:0] ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};
    localparam logic [W-1:0] FOUR       = W'(4);

    state_t       state_q, state_d;
    logic [W-1:0] pcf_q, pcf_d;
    logic [W-1:0] hold_instr_q, hold_instr_d;
    logic [W-1:0] target_q, target_d;
    logic [W-1:0] instr_q, instr_d;
    logic [W-1:0] pcplus4_q, pcplus4_d;
    logic         valid_q, valid_d;

    logic         redirect;
    logic [W-1:0] target_raw;
    logic [W-1:0] target;
    logic [W-1:0] pcf_plus4;
    logic         deliver;
    logic [W-1:0] deliver_word;

    // A redirect held back by StallD is ignored; decode re-presents it.
    assign redirect   = (JumpD | PCSrcD) & ~StallD;
    assign target_raw = JumpD ? PCJumpD : PCBranchD;
    assign target     = target_raw & ALIGN_MASK;
    assign pcf_plus4  = pcf_q + FOUR;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        hold_instr_d = hold_instr_q;
        target_d     = target_q;
        deliver      = 1'b0;
        deliver_word = '0;
        instr_d      = instr_q;
        pcplus4_d    = pcplus4_q;
        valid_d      = valid_q;

        imem_req  = reset_n & (state_q != HOLD);
        imem_addr = pcf_q;
        ImemStall = imem_req & ~imem_ack & (state_q == FETCH);

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pcf_d = target;
                    end else begin
                        // Request is in flight: keep the address, remember
                        // where to go once the stale word comes back.
                        target_d = target;
                        state_d  = DISCARD;
                    end
                end else if (imem_ack) begin
                    if (!StallF) begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        pcf_d        = pcf_plus4;
                    end else begin
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pcf_d   = target;
                    state_d = FETCH;
                end else if (!StallF) begin
                    deliver      = 1'b1;
                    deliver_word = hold_instr_q;
                    pcf_d        = pcf_plus4;
                    state_d      = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    target_d = target;
                end
                if (imem_ack) begin
                    pcf_d   = redirect ? target : target_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (!StallD) begin
            if (!redirect && deliver) begin
                instr_d   = deliver_word;
                pcplus4_d = pcf_plus4;
                valid_d   = 1'b1;
            end else begin
                instr_d   = '0;
                pcplus4_d = '0;
                valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            pcf_q        <= RESET_PC;
            hold_instr_q <= '0;
            target_q     <= '0;
            instr_q      <= '0;
            pcplus4_q    <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            hold_instr_q <= hold_instr_d;
            target_q     <= target_d;
            instr_q      <= instr_d;
            pcplus4_q    <= pcplus4_d;
            valid_q      <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCPlus4D = pcplus4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized stimulus for fetch_stage with a
// transaction-level reference model feeding request and IF/ID scoreboards.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    bit          clk;
    logic        reset_n;
    logic        StallF, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD, ImemStall;

    fetch_stage #(.W(32), .RESET_PC(RPC)) dut (
        .clk(clk), .reset_n(reset_n),
        .StallF(StallF), .StallD(StallD),
        .PCSrcD(PCSrcD), .JumpD(JumpD),
        .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .ImemStall(ImemStall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          stall;
    } rq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } dl_t;

    rq_t rq[$];
    dl_t dq[$];

    int n_vec = 0;
    int n_err = 0;
    bit active = 0;

    // Reference model: where the program counter points, whether a fetched
    // word is parked waiting for StallF to drop, and whether a stale
    // request is still outstanding with a pending redirect target.
    logic [31:0] m_pc;
    bit          m_parked;
    logic [31:0] m_parked_word;
    bit          m_stale;
    logic [31:0] m_stale_target;
    int          mem_cnt = 0;
    int          mem_lat = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic cyc(input bit rst, input bit sf, input bit sd,
                       input bit br, input bit jp,
                       input logic [31:0] bt, input logic [31:0] jt,
                       input bit ack_in, input bit rnd_mem);
        bit          req, ack, redir, dlv;
        logic [31:0] tgt, dw, dpc4;
        rq_t         r;
        req = rst && !m_parked;
        if (rnd_mem) begin
            ack = 1'b0;
            if (req) begin
                if (mem_cnt >= mem_lat) begin
                    ack     = 1'b1;
                    mem_cnt = 0;
                    mem_lat = ($urandom_range(0, 3) == 0) ? 0 :
                              $urandom_range(0, 2);
                end else begin
                    mem_cnt++;
                end
            end
        end else begin
            ack = ack_in && req;
        end
        reset_n    = rst;
        StallF     = sf;
        StallD     = sd;
        PCSrcD     = br;
        JumpD      = jp;
        PCBranchD  = bt;
        PCJumpD    = jt;
        imem_ack   = ack;
        imem_rdata = ack ? mdata(m_pc) : $urandom;
        r.req   = req;
        r.addr  = m_pc;
        r.stall = req && !ack && !m_stale;
        rq.push_back(r);
        if (!rst) begin
            m_pc     = RPC;
            m_parked = 0;
            m_stale  = 0;
            mem_cnt  = 0;
        end else begin
            redir = (br || jp) && !sd;
            tgt   = (jp ? jt : bt) & 32'hFFFF_FFFC;
            dlv   = 0;
            dw    = '0;
            dpc4  = '0;
            if (m_parked) begin
                if (redir) begin
                    m_pc     = tgt;
                    m_parked = 0;
                end else if (!sf) begin
                    dlv      = 1;
                    dw       = m_parked_word;
                    dpc4     = m_pc + 32'd4;
                    m_pc     = m_pc + 32'd4;
                    m_parked = 0;
                end
            end else if (m_stale) begin
                if (redir) m_stale_target = tgt;
                if (ack) begin
                    m_pc    = m_stale_target;
                    m_stale = 0;
                end
            end else begin
                if (redir) begin
                    if (ack) m_pc = tgt;
                    else begin
                        m_stale        = 1;
                        m_stale_target = tgt;
                    end
                end else if (ack) begin
                    if (!sf) begin
                        dlv  = 1;
                        dw   = mdata(m_pc);
                        dpc4 = m_pc + 32'd4;
                        m_pc = m_pc + 32'd4;
                    end else begin
                        m_parked      = 1;
                        m_parked_word = mdata(m_pc);
                    end
                end
            end
            if (!sd && !redir && dlv) dq.push_back('{dw, dpc4});
        end
        @(posedge clk);
        #1;
    endtask

    bit rst_e, upd_e;

    always @(posedge clk) begin
        rst_e = !reset_n;
        upd_e = !StallD;
    end

    always @(negedge clk) begin
        rq_t r;
        dl_t d;
        if (active) begin
            if (rq.size() > 0) begin
                r = rq.pop_front();
                n_vec++;
                if (imem_req !== r.req || ImemStall !== r.stall ||
                    (r.req && imem_addr !== r.addr)) begin
                    n_err++;
                    $display("FAIL req: got req=%b addr=%h stall=%b want req=%b addr=%h stall=%b",
                             imem_req, imem_addr, ImemStall, r.req, r.addr, r.stall);
                end
            end
            if (rst_e) begin
                n_vec++;
                if (ValidD !== 1'b0 || InstrD !== 32'd0 || PCPlus4D !== 32'd0) begin
                    n_err++;
                    $display("FAIL reset_ifid: got v=%b i=%h p=%h want 0/0/0",
                             ValidD, InstrD, PCPlus4D);
                end
            end else if (upd_e && ValidD === 1'b1) begin
                n_vec++;
                if (dq.size() == 0) begin
                    n_err++;
                    $display("FAIL ifid_extra: got i=%h p=%h want no delivery",
                             InstrD, PCPlus4D);
                end else begin
                    d = dq.pop_front();
                    if (InstrD !== d.instr || PCPlus4D !== d.pc4) begin
                        n_err++;
                        $display("FAIL ifid: got i=%h p=%h want i=%h p=%h",
                                 InstrD, PCPlus4D, d.instr, d.pc4);
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 0; StallF = 0; StallD = 0; PCSrcD = 0; JumpD = 0;
        PCBranchD = '0; PCJumpD = '0; imem_ack = 0; imem_rdata = '0;
        m_pc = RPC; m_parked = 0; m_stale = 0;
        m_parked_word = '0; m_stale_target = '0;
        @(posedge clk);
        #1;
        active = 1;
        // reset, then zero-wait fetch of 0x100, 0x104
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // 0x108 acked under StallF/StallD for three cycles, then release
        cyc(1, 1, 1, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // two wait states on 0x10C
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // jump while 0x110 waits -> discard, then fetch 0x400
        cyc(1, 0, 0, 0, 1, 0, 32'h400, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // branch and jump together, jump wins, low bits dropped
        cyc(1, 0, 0, 1, 1, 32'h200, 32'h303, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // redirect under StallD is ignored
        cyc(1, 1, 1, 0, 1, 0, 32'h800, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // wrap at top of address space
        cyc(1, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // reset in the middle of a discard
        cyc(1, 0, 0, 1, 0, 32'h500, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 149) != 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 11) == 0,
                $urandom, $urandom, 0, 1);
        end
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        active = 0;
        n_vec++;
        if (dq.size() != 0) begin
            n_err++;
            $display("FAIL ifid_missing: got %0d undelivered want 0", dq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter (PCF), issues requests on a ready/ack instruction-memory port, and feeds the IF/ID pipeline register (InstrD, PCPlus4D, ValidD) that the decode stage and hazard unit consume. It obeys StallF, StallD and decode-stage redirects (branch/jump), and reports memory wait states back to the hazard unit as ImemStall.

## Interface
- W, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- StallF  input  1  hold PC / fetch progress (from hazard unit)
- StallD  input  1  hold IF/ID register (from hazard unit)
- PCSrcD  input  1  taken branch in decode
- JumpD  input  1  jump in decode
- PCBranchD  input  W  branch target
- PCJumpD  input  W  jump target
- imem_req  output  1  fetch request
- imem_addr  output  W  fetch address, word aligned
- imem_ack  input  1  data valid this cycle; legal only while imem_req=1
- imem_rdata  input  W  instruction word
- InstrD  output  W  IF/ID instruction (0 = NOP when bubble)
- PCPlus4D  output  W  IF/ID PC+4 of InstrD
- ValidD  output  1  IF/ID holds a real instruction
- ImemStall  output  1  fetch waiting on memory

## Operation
- States: FETCH, HOLD, DISCARD. Holding registers: PCF, hold_instr, target_q.
- redirect = (JumpD | PCSrcD) & ~StallD; next target = JumpD ? PCJumpD : PCBranchD (JumpD wins).
- FETCH: imem_req=1, imem_addr=PCF.
  - redirect (with or without ack): returned word dropped; PCF<=target; stay FETCH, unless no ack this cycle, in which case target_q<=target, go DISCARD (PCF and imem_addr held).
  - ack, StallF=0: deliver imem_rdata; PCF<=PCF+4.
  - ack, StallF=1: hold_instr<=imem_rdata; go HOLD.
  - no ack: ImemStall=1.
- HOLD: imem_req=0. redirect: drop hold_instr, PCF<=target, go FETCH. Else StallF=0: deliver hold_instr, PCF<=PCF+4, go FETCH.
- DISCARD: imem_req=1, imem_addr=old PCF (unchanged until ack). New redirect overwrites target_q. On ack: data dropped, PCF<=target_q (or new target if redirect same cycle), go FETCH. ImemStall=0.
- IF/ID update priority: StallD=1 -> hold all three; else redirect -> bubble; else delivery -> InstrD=word, PCPlus4D=PCF+4, ValidD=1; else bubble. Bubble = InstrD=0, PCPlus4D=0, ValidD=0.
- Arithmetic: PCF+4 modulo 2^W (32'hFFFF_FFFC -> 0). PCF[1:0] always 0; target bits [1:0] ignored (forced 0).

## Timing
- Reset (reset_n=0 at edge): PCF=RESET_PC, state FETCH, InstrD=0, PCPlus4D=0, ValidD=0. During reset cycles imem_req=0, ImemStall=0. First request in cycle after reset_n rises.
- Outstanding request abandoned by reset; memory must drop it.
- imem_req/imem_addr stable from assertion until ack; never change address mid-request.
- Zero-wait memory (ack same cycle as req): one instruction per cycle, InstrD valid one edge after ack.
- Redirect penalty: one bubble (no delay slot) with zero-wait memory; wrong-path word never reaches ValidD=1.
- ImemStall combinational: imem_req & ~imem_ack & state==FETCH.

## Test plan
- Reset RESET_PC=0x100, zero-wait memory returning addr as data -> imem_addr 0x100,0x104,0x108 on consecutive cycles; InstrD 0x100 with PCPlus4D 0x104, ValidD=1 one cycle later.
- Ack at 0x108 with StallF=StallD=1 for 3 cycles -> HOLD, imem_req=0, IF/ID unchanged; release -> InstrD=0x108, next req 0x10C.
- 2-wait memory -> ImemStall=1 two cycles, ValidD=0 bubbles, then InstrD delivered; imem_addr stable throughout.
- JumpD=1 PCJumpD=0x400 while req for 0x110 waiting -> DISCARD, ImemStall=0, ack data dropped, next req 0x400, ValidD never 1 for 0x110.
- PCSrcD and JumpD together with PCBranchD=0x200, PCJumpD=0x300 -> next req 0x300; redirect with StallD=1 ignored.
- PC 0xFFFF_FFFC fetched -> PCPlus4D=0, next req 0x0; reset_n=0 mid-DISCARD -> imem_req=0, PCF=RESET_PC, ValidD=0.
